// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in, one 4-bit nibble
// per clock, least significant nibble first. Each nibble is summed with 4-bit
// carry-lookahead logic; the carry out of one nibble is registered and feeds
// the next. The result, carry out and signed overflow are registered and held
// until the next accepted start.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (priority over start)
//   start : request to begin an addition; accepted in IDLE or DONE
//   a, b  : W-bit operands, captured on an accepted start
//   cin   : carry-in, captured on an accepted start
//   busy  : high while nibbles are being added (state ADD)
//   done  : single-cycle pulse, result valid (state DONE)
//   s     : registered sum; shows the partial sum while busy
//   cout  : registered carry out of the MSB
//   ovf   : registered two's-complement overflow flag
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Select the operand nibbles addressed by idx
  // ---------------------------------------------------------------------------
  logic [3:0] a_nib, b_nib;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 4-bit carry lookahead on the selected nibble
  // ---------------------------------------------------------------------------
  logic [3:0] p, g, sum_nib;
  logic       c1, c2, c3, c4;

  assign p = a_nib ^ b_nib;
  assign g = a_nib & b_nib;

  assign c1 = g[0] | (p[0] & carry_q);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & carry_q);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry_q);

  assign sum_nib = p ^ {c3, c2, c1, carry_q};

  // ---------------------------------------------------------------------------
  // Sum register with the current nibble slot replaced by the new sum nibble
  // ---------------------------------------------------------------------------
  logic [W-1:0] s_wr;

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib_wr
      assign s_wr[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? sum_nib : s_q[4*gi +: 4];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          s_d     = '0;
        end
      end

      ADD: begin
        // start is deliberately not examined here: operands stay frozen
        s_d     = s_wr;
        carry_d = c4;
        if (idx_q == LAST_IDX) begin
          // idx is left at its last value so it never wraps
          state_d = DONE;
          cout_d  = c4;
          ovf_d   = c3 ^ c4;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (start) begin
          state_d = ADD;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          s_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
